shifter_rl_seq: RTL

Sequential right shifter, the counterpart of the combinational left-logical shifter family. It accepts an operand and shift amount over a valid/ready handshake and shifts right one position per clock. Fill is logical (zeros) or arithmetic (sign copies). The result is returned over a second valid/ready handshake. It sits in the ALU datapath where area matters more than single-cycle latency.

---
 rtl/shifter_rl_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/shifter_rl_seq.sv
// Sequential right shifter: accepts an operand over valid/ready, shifts right one
// bit per clock with logical or arithmetic fill, and returns the result over valid/ready.
module shifter_rl_seq #(
    parameter int N = 8,
    localparam int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [S-1:0] s,
    input  logic         arith,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [S-1:0]  count_q, count_d;
    logic          mode_q, mode_d;
    logic [N-1:0]  y_q, y_d;

    // One-bit right shift; the fill bit is the sign only in arithmetic mode.
    function automatic logic [N-1:0] shr1(input logic [N-1:0] v, input logic arith_mode);
        return {arith_mode & v[N-1], v[N-1:1]};
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = a;
                    mode_d = arith;
                    if (s == S'(0)) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = s;
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_d  = shr1(data_q, mode_q);
                count_d = count_q - S'(1);
                if (count_q == S'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result is captured on entry to DONE so y holds steady until the next result.
    always_comb begin
        if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
            y_d = data_d;
        end else begin
            y_d = y_q;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    assign y = y_q;

endmodule
